sysbus_mem_responder: RTL and testbench

- Memory-side responder for the processor's multiplexed SysBus.
- Latches the address on ALE and decodes nME/nOE/nWE strobes into single-cycle requests to a synchronous single-port RAM macro.
- Drives read data back onto the bus in the cycle the processor samples it (ENB).
- Sits between the pad-level SysBus, with the tristate resolved outside this block, and the on-chip RAM.

---
 rtl/sysbus_pkg.sv | 20 ++
 rtl/sysbus_addr_decode.sv | 29 ++
 rtl/sysbus_mem_responder.sv | 123 ++++++++++++
 tb/tb_sysbus_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_pkg.sv
// Shared types, default widths and address decode helper for the SysBus memory responder.
package sysbus_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_RAM_AW = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD1,
        ST_RD2,
        ST_WR
    } state_e;

    // True when every address bit above the RAM word-address range is zero.
    function automatic logic is_mapped(input logic [31:0] addr, input int unsigned aw);
        return (addr >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/sysbus_addr_decode.sv
// Address latch for the multiplexed bus plus mapped/unmapped decode of the held address.
module sysbus_addr_decode
    import sysbus_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RAM_AW = DEF_RAM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] addr_in,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              mapped
);

    logic [DATA_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= addr_in;
        end
    end

    assign ram_addr = addr_q[RAM_AW-1:0];
    assign mapped   = is_mapped(32'(addr_q), RAM_AW);

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side SysBus responder: decodes ALE/nME/nOE/nWE into single-cycle RAM requests
// and returns read data on the bus in the second cycle of the read strobe.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RAM_AW = DEF_RAM_AW
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] SysBusIn,
    output logic [DATA_W-1:0] SysBusOut,
    output logic              SysBusOe,
    input  logic              ALE,
    input  logic              nME,
    input  logic              nOE,
    input  logic              nWE,
    output logic              RamEn,
    output logic              RamWe,
    output logic [RAM_AW-1:0] RamAddr,
    output logic [DATA_W-1:0] RamWData,
    input  logic [DATA_W-1:0] RamRData,
    output logic              BusErr,
    input  logic              ErrClr
);

    state_e            state_q, state_d;
    logic              load, err_set, ram_en, ram_we, bus_oe, mapped;
    logic [RAM_AW-1:0] ram_addr;

    sysbus_addr_decode #(.DATA_W(DATA_W), .RAM_AW(RAM_AW)) u_addr_decode (
        .clk      (Clock),
        .rst      (Reset),
        .load     (load),
        .addr_in  (SysBusIn),
        .ram_addr (ram_addr),
        .mapped   (mapped)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            BusErr <= 1'b0;
        end else if (err_set) begin
            BusErr <= 1'b1;
        end else if (ErrClr) begin
            BusErr <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        err_set = 1'b0;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        bus_oe  = 1'b0;
        if (ALE && nME) begin
            load    = 1'b1;
            state_d = ST_ADDR;
        end else if (ALE) begin
            err_set = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_ADDR: begin
                    if (!nME) begin
                        if (!nOE && !nWE) begin
                            err_set = 1'b1;
                            state_d = ST_WR;
                        end else if (!nOE) begin
                            ram_en  = mapped;
                            err_set = !mapped;
                            state_d = ST_RD1;
                        end else if (!nWE) begin
                            ram_en  = mapped;
                            ram_we  = mapped;
                            err_set = !mapped;
                            state_d = ST_WR;
                        end
                    end
                end
                // RAM data is valid the cycle after the request and held while the strobe lasts.
                ST_RD1, ST_RD2: begin
                    if (nME) begin
                        state_d = ST_IDLE;
                    end else begin
                        bus_oe  = !nOE;
                        state_d = ST_RD2;
                    end
                end
                ST_WR: begin
                    if (nME) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (Reset) begin
            ram_en = 1'b0;
            ram_we = 1'b0;
            bus_oe = 1'b0;
        end
    end

    assign RamEn     = ram_en;
    assign RamWe     = ram_we;
    assign RamAddr   = ram_en ? ram_addr : '0;
    assign RamWData  = ram_we ? SysBusIn : '0;
    assign SysBusOe  = bus_oe;
    assign SysBusOut = (bus_oe && mapped) ? RamRData : '0;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder with a behavioural single-port RAM on the RAM side.
module tb_sysbus_mem_responder;

    logic        Clock, Reset;
    logic [15:0] SysBusIn, SysBusOut, RamWData, RamRData;
    logic        SysBusOe, ALE, nME, nOE, nWE, RamEn, RamWe, BusErr, ErrClr;
    logic [9:0]  RamAddr;

    logic [15:0] mem [0:1023];
    int          wr_cnt;
    int          checks = 0;
    int          errors = 0;
    int          w0;

    sysbus_mem_responder dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .SysBusIn  (SysBusIn),
        .SysBusOut (SysBusOut),
        .SysBusOe  (SysBusOe),
        .ALE       (ALE),
        .nME       (nME),
        .nOE       (nOE),
        .nWE       (nWE),
        .RamEn     (RamEn),
        .RamWe     (RamWe),
        .RamAddr   (RamAddr),
        .RamWData  (RamWData),
        .RamRData  (RamRData),
        .BusErr    (BusErr),
        .ErrClr    (ErrClr)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM: one-cycle read latency, output held until the next read.
    always @(posedge Clock) begin
        if (Reset) begin
            mem[10'h012] <= 16'hBEEF;
            wr_cnt       <= 0;
        end else if (RamEn) begin
            if (RamWe) begin
                mem[RamAddr] <= RamWData;
                wr_cnt       <= wr_cnt + 1;
            end else begin
                RamRData <= mem[RamAddr];
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ale, input logic nme, input logic noe, input logic nwe,
                         input logic [15:0] bus);
        ALE      = ale;
        nME      = nme;
        nOE      = noe;
        nWE      = nwe;
        SysBusIn = bus;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        drive(1, 1, 1, 1, addr);
        step();
        drive(0, 0, 0, 1, 16'h0000);
        step();
        @(negedge Clock);
        check({tag, "_oe"}, 16'(SysBusOe), 16'd1);
        check({tag, "_data"}, SysBusOut, exp);
        step();
        drive(0, 1, 1, 1, 16'h0000);
        step();
    endtask

    initial begin
        Clock    = 1'b0;
        Reset    = 1'b1;
        ErrClr   = 1'b0;
        RamRData = 16'h0000;
        drive(0, 1, 1, 1, 16'h0000);
        step();
        step();

        // Strobes asserted while in reset must not produce any output.
        drive(0, 0, 0, 1, 16'h0000);
        @(negedge Clock);
        check("rst_ram_en", 16'(RamEn), 16'd0);
        check("rst_oe", 16'(SysBusOe), 16'd0);
        check("rst_out", SysBusOut, 16'h0000);
        check("rst_err", 16'(BusErr), 16'd0);
        check("rst_addr", 16'(RamAddr), 16'h0000);
        step();
        Reset = 1'b0;
        drive(0, 1, 1, 1, 16'h0000);
        step();

        // Read 0x012 with a three-cycle strobe.
        drive(1, 1, 1, 1, 16'h0012);
        step();
        drive(0, 0, 0, 1, 16'h0000);
        @(negedge Clock);
        check("rd_en", 16'(RamEn), 16'd1);
        check("rd_we", 16'(RamWe), 16'd0);
        check("rd_addr", 16'(RamAddr), 16'h0012);
        check("rd_oe_c1", 16'(SysBusOe), 16'd0);
        step();
        @(negedge Clock);
        check("rd_oe", 16'(SysBusOe), 16'd1);
        check("rd_data", SysBusOut, 16'hBEEF);
        check("rd_c2_en", 16'(RamEn), 16'd0);
        step();
        @(negedge Clock);
        check("rd_hold_data", SysBusOut, 16'hBEEF);
        step();
        drive(0, 1, 1, 1, 16'h0000);
        @(negedge Clock);
        check("rd_end_oe", 16'(SysBusOe), 16'd0);
        check("rd_end_out", SysBusOut, 16'h0000);
        step();

        // Write 0x1234 to 0x034 with a two-cycle strobe: exactly one RAM write.
        drive(1, 1, 1, 1, 16'h0034);
        step();
        w0 = wr_cnt;
        drive(0, 0, 1, 0, 16'h1234);
        @(negedge Clock);
        check("wr_en", 16'(RamEn), 16'd1);
        check("wr_we", 16'(RamWe), 16'd1);
        check("wr_addr", 16'(RamAddr), 16'h0034);
        check("wr_wdata", RamWData, 16'h1234);
        step();
        @(negedge Clock);
        check("wr_hold_en", 16'(RamEn), 16'd0);
        check("wr_hold_oe", 16'(SysBusOe), 16'd0);
        step();
        drive(0, 1, 1, 1, 16'h0000);
        @(negedge Clock);
        check("wr_pulses", 16'(wr_cnt - w0), 16'd1);
        step();
        bus_read(16'h0034, 16'h1234, "wr_readback");

        // Unmapped read.
        drive(1, 1, 1, 1, 16'h8000);
        step();
        drive(0, 0, 0, 1, 16'h0000);
        @(negedge Clock);
        check("um_en", 16'(RamEn), 16'd0);
        check("um_err_pre", 16'(BusErr), 16'd0);
        step();
        @(negedge Clock);
        check("um_out", SysBusOut, 16'h0000);
        check("um_en2", 16'(RamEn), 16'd0);
        check("um_err", 16'(BusErr), 16'd1);
        step();
        drive(0, 1, 1, 1, 16'h0000);
        ErrClr = 1'b1;
        step();
        ErrClr = 1'b0;
        @(negedge Clock);
        check("um_clr", 16'(BusErr), 16'd0);

        // ALE with nME low is a protocol error; it wins over a same-cycle clear.
        drive(1, 0, 1, 1, 16'h0055);
        ErrClr = 1'b1;
        step();
        ErrClr = 1'b0;
        drive(0, 1, 1, 1, 16'h0000);
        @(negedge Clock);
        check("set_wins", 16'(BusErr), 16'd1);
        ErrClr = 1'b1;
        step();
        ErrClr = 1'b0;
        @(negedge Clock);
        check("set_wins_clr", 16'(BusErr), 16'd0);

        // Conflicting strobes.
        drive(1, 1, 1, 1, 16'h0010);
        step();
        w0 = wr_cnt;
        drive(0, 0, 0, 0, 16'hAAAA);
        @(negedge Clock);
        check("cf_en", 16'(RamEn), 16'd0);
        check("cf_oe", 16'(SysBusOe), 16'd0);
        step();
        @(negedge Clock);
        check("cf_en2", 16'(RamEn), 16'd0);
        check("cf_oe2", 16'(SysBusOe), 16'd0);
        check("cf_err", 16'(BusErr), 16'd1);
        check("cf_no_write", 16'(wr_cnt - w0), 16'd0);
        step();
        drive(0, 1, 1, 1, 16'h0000);
        ErrClr = 1'b1;
        step();
        ErrClr = 1'b0;

        // Reset in the RD2 cycle, then residual strobe must be ignored.
        drive(1, 1, 1, 1, 16'h0012);
        step();
        drive(0, 0, 0, 1, 16'h0000);
        step();
        step();
        Reset = 1'b1;
        @(negedge Clock);
        check("rs_oe", 16'(SysBusOe), 16'd0);
        check("rs_out", SysBusOut, 16'h0000);
        step();
        Reset = 1'b0;
        @(negedge Clock);
        check("rs_resid_oe", 16'(SysBusOe), 16'd0);
        check("rs_resid_en", 16'(RamEn), 16'd0);
        check("rs_err", 16'(BusErr), 16'd0);
        step();
        drive(0, 1, 1, 1, 16'h0000);
        step();
        bus_read(16'h0012, 16'hBEEF, "rs_after");

        // Back-to-back fetch read then write then readback, no idle cycles.
        drive(1, 1, 1, 1, 16'h0012);
        step();
        drive(0, 0, 0, 1, 16'h0000);
        step();
        @(negedge Clock);
        check("b2b_fetch", SysBusOut, 16'hBEEF);
        step();
        drive(1, 1, 1, 1, 16'h0020);
        step();
        drive(0, 0, 1, 0, 16'h5555);
        @(negedge Clock);
        check("b2b_wr_en", 16'(RamEn & RamWe), 16'd1);
        check("b2b_wr_addr", 16'(RamAddr), 16'h0020);
        step();
        drive(1, 1, 1, 1, 16'h0020);
        step();
        drive(0, 0, 0, 1, 16'h0000);
        step();
        @(negedge Clock);
        check("b2b_rd_oe", 16'(SysBusOe), 16'd1);
        check("b2b_rd_data", SysBusOut, 16'h5555);
        check("b2b_err", 16'(BusErr), 16'd0);
        step();
        drive(0, 1, 1, 1, 16'h0000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
